pc_vector_sequencer: RTL and testbench

PC_VECTOR_SEQUENCER -- requirements
Module: pc_vector_sequencer

---
 rtl/pc_vector_sequencer_pkg.sv | 31 +++
 rtl/pc_vector_sequencer_if.sv | 34 +++
 rtl/vec_table_ram.sv | 26 ++
 rtl/pc_vector_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_pc_vector_sequencer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_vector_sequencer_pkg.sv
// Shared types for the PC vector sequencer: FSM states, vector-table entry record
// and the NOP used as the flush trailer.
package pc_vector_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RST,
      WAIT_V,
      PRESENT,
      GRADE,
      DONE
   } seq_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
   } vec_entry_t;

   // Trailer entry: its expected fields are never graded, so zero them.
   function automatic vec_entry_t nop_entry();
      vec_entry_t e;
      e.instr     = NOP_INSTR;
      e.exp_addr  = 32'h0;
      e.exp_wdata = 32'h0;
      return e;
   endfunction

endpackage

// File: rtl/pc_vector_sequencer_if.sv
// Driver-side bus of the vector sequencer: the presented vector, the
// pc_ready/pc_valid handshake, driver reset and the driver's check results.
interface pc_vector_sequencer_if;
   logic [31:0] instruction;
   logic [31:0] input_output_write_data;
   logic [31:0] output_addr_data;
   logic        pc_ready;
   logic        driver_reset;
   logic        pc_valid;
   logic        output_addr_data_pass;
   logic        output_write_data_pass;

   modport master (
      output instruction,
      output input_output_write_data,
      output output_addr_data,
      output pc_ready,
      output driver_reset,
      input  pc_valid,
      input  output_addr_data_pass,
      input  output_write_data_pass
   );

   modport slave (
      input  instruction,
      input  input_output_write_data,
      input  output_addr_data,
      input  pc_ready,
      input  driver_reset,
      output pc_valid,
      output output_addr_data_pass,
      output output_write_data_pass
   );
endinterface

// File: rtl/vec_table_ram.sv
// Vector table: one write port, one registered read port, 96-bit entries.
// Contents are deliberately not reset so a table survives an aborted run.
module vec_table_ram
   import pc_vector_sequencer_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_idx,
   input  vec_entry_t    wr_data,
   input  logic [AW-1:0] rd_idx,
   output vec_entry_t    rd_data
);

   vec_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_idx] <= wr_data;
      end
      rd_data <= mem[rd_idx];
   end

endmodule

// File: rtl/pc_vector_sequencer.sv
// Presents a table of test vectors to a pipelined CPU driver, grading each
// vector from the driver's pass flags one handshake later.
module pc_vector_sequencer
   import pc_vector_sequencer_pkg::*;
#(
   parameter int DEPTH      = 64,
   parameter int AW         = 6,
   parameter int RST_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_en,
   input  logic [AW-1:0]         load_idx,
   input  logic [31:0]           load_instr,
   input  logic [31:0]           load_exp_addr,
   input  logic [31:0]           load_exp_wdata,
   input  logic                  start,
   input  logic [AW:0]           num_vectors,
   pc_vector_sequencer_if.master drv,
   output logic                  busy,
   output logic                  done,
   output logic [AW:0]           pass_count,
   output logic [AW:0]           fail_count,
   output logic [AW-1:0]         first_fail_idx,
   output logic                  fail_seen
);

   localparam int          RCW     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
   localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
   localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

   seq_state_t     state_reg, state_next;
   logic [AW:0]    k_reg, k_next;
   logic [AW:0]    num_reg, num_next;
   logic [RCW-1:0] rst_cnt_reg, rst_cnt_next;
   logic           have_prior_reg, have_prior_next;
   logic           trailer_reg, trailer_next;
   logic           prev_valid_reg;
   logic [AW:0]    pass_reg, pass_next;
   logic [AW:0]    fail_reg, fail_next;
   logic [AW-1:0]  ffi_reg, ffi_next;
   logic           fseen_reg, fseen_next;
   logic [31:0]    instr_reg, instr_next;
   logic [31:0]    addr_reg, addr_next;
   logic [31:0]    wdata_reg, wdata_next;
   logic           pc_ready_reg, pc_ready_next;
   logic           drv_rst_reg, drv_rst_next;

   vec_entry_t     wr_entry;
   vec_entry_t     rd_entry;
   vec_entry_t     cur_entry;
   logic           idle_or_done;
   logic           count_ok;
   logic [AW:0]    k_plus_one;
   logic [AW:0]    k_minus_one;

   assign idle_or_done = (state_reg == IDLE) || (state_reg == DONE);
   assign count_ok     = (num_vectors != '0) && (num_vectors <= DEPTH_C);
   assign k_plus_one   = k_reg + ONE_C;
   assign k_minus_one  = k_reg - ONE_C;
   assign cur_entry    = trailer_reg ? nop_entry() : rd_entry;

   assign wr_entry.instr     = load_instr;
   assign wr_entry.exp_addr  = load_exp_addr;
   assign wr_entry.exp_wdata = load_exp_wdata;

   // Read address follows k_next so table[k] is ready on the first WAIT_V cycle.
   vec_table_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_table (
      .clk     (clk),
      .we      (load_en && idle_or_done),
      .wr_idx  (load_idx),
      .wr_data (wr_entry),
      .rd_idx  (k_next[AW-1:0]),
      .rd_data (rd_entry)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      k_next          = k_reg;
      num_next        = num_reg;
      rst_cnt_next    = rst_cnt_reg;
      have_prior_next = have_prior_reg;
      trailer_next    = trailer_reg;
      pass_next       = pass_reg;
      fail_next       = fail_reg;
      ffi_next        = ffi_reg;
      fseen_next      = fseen_reg;
      instr_next      = instr_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      pc_ready_next   = pc_ready_reg;

      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               k_next          = '0;
               num_next        = num_vectors;
               rst_cnt_next    = '0;
               have_prior_next = 1'b0;
               trailer_next    = 1'b0;
               pass_next       = '0;
               fail_next       = '0;
               ffi_next        = '0;
               fseen_next      = 1'b0;
               state_next      = count_ok ? RST : DONE;
            end
         end
         RST: begin
            if (rst_cnt_reg == RST_LAST) begin
               state_next = WAIT_V;
            end else begin
               rst_cnt_next = rst_cnt_reg + 1'b1;
            end
         end
         WAIT_V: begin
            instr_next    = cur_entry.instr;
            addr_next     = cur_entry.exp_addr;
            wdata_next    = cur_entry.exp_wdata;
            pc_ready_next = 1'b1;
            // Only hand over once the vector is actually visible on the bus.
            if (drv.pc_valid && pc_ready_reg) begin
               state_next = PRESENT;
            end
         end
         PRESENT: begin
            if (prev_valid_reg && !drv.pc_valid) begin
               state_next    = GRADE;
               pc_ready_next = 1'b0;
            end
         end
         GRADE: begin
            // Flags now describe vector k-1; the first sample of a run has no owner.
            if (have_prior_reg) begin
               if (drv.output_addr_data_pass && drv.output_write_data_pass) begin
                  if (pass_reg != DEPTH_C) pass_next = pass_reg + ONE_C;
               end else begin
                  if (fail_reg != DEPTH_C) fail_next = fail_reg + ONE_C;
                  if (!fseen_reg) begin
                     fseen_next = 1'b1;
                     ffi_next   = k_minus_one[AW-1:0];
                  end
               end
            end
            have_prior_next = 1'b1;
            if (trailer_reg) begin
               state_next = DONE;
            end else begin
               k_next       = k_plus_one;
               trailer_next = (k_plus_one == num_reg);
               state_next   = WAIT_V;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      drv_rst_next = (state_next == RST);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         k_reg          <= '0;
         num_reg        <= '0;
         rst_cnt_reg    <= '0;
         have_prior_reg <= 1'b0;
         trailer_reg    <= 1'b0;
         prev_valid_reg <= 1'b0;
         pass_reg       <= '0;
         fail_reg       <= '0;
         ffi_reg        <= '0;
         fseen_reg      <= 1'b0;
         instr_reg      <= '0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         pc_ready_reg   <= 1'b0;
         drv_rst_reg    <= 1'b1;
      end else begin
         k_reg          <= k_next;
         num_reg        <= num_next;
         rst_cnt_reg    <= rst_cnt_next;
         have_prior_reg <= have_prior_next;
         trailer_reg    <= trailer_next;
         prev_valid_reg <= drv.pc_valid;
         pass_reg       <= pass_next;
         fail_reg       <= fail_next;
         ffi_reg        <= ffi_next;
         fseen_reg      <= fseen_next;
         instr_reg      <= instr_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
         pc_ready_reg   <= pc_ready_next;
         drv_rst_reg    <= drv_rst_next;
      end
   end

   assign drv.instruction             = instr_reg;
   assign drv.output_addr_data        = addr_reg;
   assign drv.input_output_write_data = wdata_reg;
   assign drv.pc_ready                = pc_ready_reg;
   assign drv.driver_reset            = drv_rst_reg;

   assign busy           = !idle_or_done;
   assign done           = (state_reg == DONE);
   assign pass_count     = pass_reg;
   assign fail_count     = fail_reg;
   assign first_fail_idx = ffi_reg;
   assign fail_seen      = fseen_reg;

endmodule

// File: tb/tb_pc_vector_sequencer.sv
// Directed bench: a pipelined driver model reports each vector's result one
// handshake late; run counts and presented vectors are checked against constants.
module tb_pc_vector_sequencer;

   localparam int DEPTH      = 64;
   localparam int AW         = 6;
   localparam int NW         = AW + 1;
   localparam int RST_CYCLES = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_en;
   logic [AW-1:0] load_idx;
   logic [31:0]   load_instr, load_exp_addr, load_exp_wdata;
   logic          start;
   logic [AW:0]   num_vectors;
   logic          busy, done, fail_seen;
   logic [AW:0]   pass_count, fail_count;
   logic [AW-1:0] first_fail_idx;

   pc_vector_sequencer_if drv_if ();

   pc_vector_sequencer #(
      .DEPTH      (DEPTH),
      .AW         (AW),
      .RST_CYCLES (RST_CYCLES)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .load_en        (load_en),
      .load_idx       (load_idx),
      .load_instr     (load_instr),
      .load_exp_addr  (load_exp_addr),
      .load_exp_wdata (load_exp_wdata),
      .start          (start),
      .num_vectors    (num_vectors),
      .drv            (drv_if),
      .busy           (busy),
      .done           (done),
      .pass_count     (pass_count),
      .fail_count     (fail_count),
      .first_fail_idx (first_fail_idx),
      .fail_seen      (fail_seen)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] t_instr [DEPTH];
   logic [31:0] t_addr  [DEPTH];
   logic [31:0] t_wdata [DEPTH];

   int hs, drst, rdy_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] good_instr(input int i);
      return 32'h0040_0013 + 32'(i) * 32'h100;
   endfunction

   task automatic load(input int i, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] w);
      load_en        = 1'b1;
      load_idx       = AW'(i);
      load_instr     = ins;
      load_exp_addr  = a;
      load_exp_wdata = w;
      t_instr[i] = ins;
      t_addr[i]  = a;
      t_wdata[i] = w;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   // Driver executes instr as addr = instr + 0x100, wdata = ~instr.
   task automatic load_good(input int i);
      load(i, good_instr(i), good_instr(i) + 32'h100, ~good_instr(i));
   endtask

   task automatic run(input int n, input int abort_hs, input bit poke);
      int          phase = 0;
      int          cycles = 0;
      bit          have_p = 1'b0;
      logic [31:0] c_instr, c_addr, c_wdata, p_instr, p_addr, p_wdata, e_instr;
      c_instr = '0; c_addr = '0; c_wdata = '0; e_instr = '0;
      p_instr = '0; p_addr = '0; p_wdata = '0;
      hs = 0; drst = 0; rdy_seen = 0;
      num_vectors = NW'(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!done && cycles < 3000) begin
         if (drv_if.driver_reset) drst++;
         if (drv_if.pc_ready) rdy_seen++;
         if (poke && cycles == 1) begin
            start = 1'b1; num_vectors = NW'(1);
            load_en = 1'b1; load_idx = '0;
            load_instr = 32'hDEAD_BEEF; load_exp_addr = 32'h1; load_exp_wdata = 32'h2;
         end else begin
            start = 1'b0; load_en = 1'b0;
         end
         case (phase)
            0: if (drv_if.pc_ready) begin
               c_instr = drv_if.instruction;
               c_addr  = drv_if.output_addr_data;
               c_wdata = drv_if.input_output_write_data;
               if (hs < n) begin
                  e_instr = t_instr[hs];
                  check($sformatf("instr[%0d]", hs), c_instr, t_instr[hs]);
                  check($sformatf("exp_addr[%0d]", hs), c_addr, t_addr[hs]);
                  check($sformatf("exp_wdata[%0d]", hs), c_wdata, t_wdata[hs]);
               end else begin
                  e_instr = NOP;
                  check("trailer_instr", c_instr, NOP);
                  check("trailer_fields", c_addr | c_wdata, 32'h0);
               end
               drv_if.pc_valid = 1'b1;
               phase = 1;
            end
            1: begin
               check("present_stable", drv_if.instruction, e_instr);
               if (hs == abort_hs) begin
                  reset = 1'b1;
                  #1;
                  check("abort_instr", drv_if.instruction, 32'h0);
                  check("abort_pc_ready", 32'(drv_if.pc_ready), 32'h0);
                  check("abort_busy", 32'(busy), 32'h0);
                  check("abort_done", 32'(done), 32'h0);
                  check("abort_driver_reset", 32'(drv_if.driver_reset), 32'h1);
                  check("abort_pass", 32'(pass_count), 32'h0);
                  check("abort_fail_seen", 32'(fail_seen), 32'h0);
                  drv_if.pc_valid = 1'b0;
                  @(negedge clk);
                  reset = 1'b0;
                  @(negedge clk);
                  check("abort_driver_reset_drop", 32'(drv_if.driver_reset), 32'h0);
                  $display("run n=%0d aborted at handshake %0d", n, hs);
                  return;
               end
               drv_if.pc_valid = 1'b0;
               phase = 2;
            end
            default: begin
               if (have_p) begin
                  drv_if.output_addr_data_pass  = (p_instr + 32'h100 == p_addr);
                  drv_if.output_write_data_pass = (~p_instr == p_wdata);
               end else begin
                  drv_if.output_addr_data_pass  = 1'b0;
                  drv_if.output_write_data_pass = 1'b0;
               end
               p_instr = c_instr; p_addr = c_addr; p_wdata = c_wdata;
               have_p = 1'b1;
               hs++;
               phase = 0;
            end
         endcase
         @(negedge clk);
         cycles++;
      end
      start = 1'b0;
      load_en = 1'b0;
      if (!done) check("run_timeout", 32'(done), 32'h1);
      $display("run n=%0d: handshakes=%0d rst_cycles=%0d pass=%0d fail=%0d first_fail=%0d",
               n, hs, drst, pass_count, fail_count, first_fail_idx);
   endtask

   task automatic check_run(input int n, input int p, input int f, input int fs, input int ffi);
      int exp_hs = (n == 0) ? 0 : n + 1;
      int exp_rs = (n == 0) ? 0 : RST_CYCLES;
      check("handshakes", 32'(hs), 32'(exp_hs));
      check("driver_reset_cycles", 32'(drst), 32'(exp_rs));
      if (n == 0) check("no_pc_ready", 32'(rdy_seen), 32'h0);
      check("done", 32'(done), 32'h1);
      check("busy", 32'(busy), 32'h0);
      check("pass_count", 32'(pass_count), 32'(p));
      check("fail_count", 32'(fail_count), 32'(f));
      check("fail_seen", 32'(fail_seen), 32'(fs));
      check("first_fail_idx", 32'(first_fail_idx), 32'(ffi));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; num_vectors = '0;
      load_en = 1'b0; load_idx = '0;
      load_instr = '0; load_exp_addr = '0; load_exp_wdata = '0;
      drv_if.pc_valid = 1'b0;
      drv_if.output_addr_data_pass = 1'b0;
      drv_if.output_write_data_pass = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_instr", drv_if.instruction, 32'h0);
      check("rst_pc_ready", 32'(drv_if.pc_ready), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_fail_seen", 32'(fail_seen), 32'h0);
      check("rst_driver_reset", 32'(drv_if.driver_reset), 32'h1);
      reset = 1'b0;
      @(negedge clk);
      check("driver_reset_release", 32'(drv_if.driver_reset), 32'h0);

      for (int i = 0; i < DEPTH; i++) load_good(i);

      run(3, -1, 1'b0);
      check_run(3, 3, 0, 0, 0);

      load(1, good_instr(1), good_instr(1) + 32'h104, ~good_instr(1));
      run(3, -1, 1'b0);
      check_run(3, 2, 1, 1, 1);

      run(0, -1, 1'b0);
      check_run(0, 0, 0, 0, 0);
      run(65, -1, 1'b0);
      check_run(0, 0, 0, 0, 0);

      load_good(1);
      run(3, 2, 1'b0);
      run(3, -1, 1'b0);
      check_run(3, 3, 0, 0, 0);

      run(3, -1, 1'b1);
      check_run(3, 3, 0, 0, 0);
      run(3, -1, 1'b0);
      check_run(3, 3, 0, 0, 0);

      run(64, -1, 1'b0);
      check_run(64, 64, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_vec);
      $fatal(1, "watchdog");
   end

endmodule
